// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stall/flush enables for load-use, taken branch,
// data-memory wait and multi-cycle mul/div, plus mul/div watchdog and stall counter.
module hazard_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_uses_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_memRead,
  input  logic             ID_EX_muldiv,
  input  logic             EX_branch_taken,
  input  logic             mem_busy,
  input  logic             md_done,
  output logic             md_start,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             ID_EX_en,
  output logic             EX_MEM_en,
  output logic             MEM_WB_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             EX_MEM_flush,
  output logic             md_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int MCW = $clog2(MD_TIMEOUT + 1);

  typedef enum logic {RUN, MD_WAIT} state_t;

  typedef struct packed {
    logic md_start;
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } ctl_t;

  localparam ctl_t CTL_RUN  = ctl_t'(9'b0_11111_000);
  localparam ctl_t CTL_OFF  = ctl_t'(9'b0_00000_000);
  localparam ctl_t CTL_MDST = ctl_t'(9'b1_00011_001);
  localparam ctl_t CTL_MDWT = ctl_t'(9'b0_00011_001);
  localparam ctl_t CTL_BR   = ctl_t'(9'b0_11111_110);
  localparam ctl_t CTL_LU   = ctl_t'(9'b0_00111_010);

  state_t           state, nxt_state;
  logic [MCW-1:0]   md_cnt, nxt_cnt;
  logic             set_err;
  logic             lu_hazard;
  logic             md_last;
  ctl_t             ctl;

  assign lu_hazard = ID_EX_memRead && (ID_EX_rd != 5'd0) &&
                     ((ID_EX_rd == ID_RS1) || (ID_uses_rs2 && (ID_EX_rd == ID_RS2)));
  assign md_last   = (md_cnt == MCW'(MD_TIMEOUT - 1));

  always_comb begin
    ctl       = CTL_RUN;
    nxt_state = state;
    nxt_cnt   = md_cnt;
    set_err   = 1'b0;
    if (!rst_n || mem_busy) begin
      // memory wait freezes everything, including the watchdog
      ctl = CTL_OFF;
    end else if (state == RUN && ID_EX_muldiv) begin
      ctl       = CTL_MDST;
      nxt_state = MD_WAIT;
      nxt_cnt   = '0;
    end else if (state == MD_WAIT) begin
      if (md_done || md_last) begin
        nxt_state = RUN;
        nxt_cnt   = '0;
        set_err   = !md_done;
      end else begin
        ctl     = CTL_MDWT;
        nxt_cnt = md_cnt + MCW'(1);
      end
    end else if (EX_branch_taken) begin
      ctl = CTL_BR;
    end else if (lu_hazard) begin
      ctl = CTL_LU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      md_cnt      <= '0;
      md_error    <= 1'b0;
      stall_count <= '0;
    end else begin
      state  <= nxt_state;
      md_cnt <= nxt_cnt;
      if (set_err) md_error <= 1'b1;
      if (!ctl.pc_en && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign md_start     = ctl.md_start;
  assign pc_en        = ctl.pc_en;
  assign IF_ID_en     = ctl.if_id_en;
  assign ID_EX_en     = ctl.id_ex_en;
  assign EX_MEM_en    = ctl.ex_mem_en;
  assign MEM_WB_en    = ctl.mem_wb_en;
  assign IF_ID_flush  = ctl.if_id_flush;
  assign ID_EX_flush  = ctl.id_ex_flush;
  assign EX_MEM_flush = ctl.ex_mem_flush;

endmodule
